// File: rtl/lcd_score_writer.sv
// Purpose: drives an HD44780 character LCD (8-bit, write-only) with power-up, init and score rewrites.
// Latency: POWERUP_CYC to the first byte; each byte costs 1 + EN_PULSE_CYC + wait cycles (ADDR + 3 chars per score).
// Backpressure: none upstream; one-deep pending buffer, a newer score overwrites an unserved one. Optional: LCD_LABEL_EN.
module lcd_score_writer #(
  parameter int POWERUP_CYC  = 750000,
  parameter int EN_PULSE_CYC = 25,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000
) (
  input  logic        clk_in,
  input  logic        i_rst_n,
  input  logic [23:0] placar_in,
  input  logic        en_placar,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        busy,
  output logic        init_done
);

  localparam int MAX_CYC = (POWERUP_CYC > CLR_WAIT_CYC) ? POWERUP_CYC : CLR_WAIT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_WAIT_CYC - 1);

`ifdef LCD_LABEL_EN
  localparam logic [3:0] INIT_LAST = 4'd11;
  localparam logic [7:0] ADDR_BYTE = 8'h87;
`else
  localparam logic [3:0] INIT_LAST = 4'd3;
  localparam logic [7:0] ADDR_BYTE = 8'h80;
`endif

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_IDLE, S_ADDR, S_CHAR0, S_CHAR1, S_CHAR2
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

  // Init byte table as {rs, data}; the label tail only exists when enabled.
  function automatic logic [8:0] init_byte(input logic [3:0] idx);
    logic [8:0] b;
    case (idx)
      4'd0:    b = 9'h038;
      4'd1:    b = 9'h00C;
      4'd2:    b = 9'h006;
      4'd3:    b = 9'h001;
`ifdef LCD_LABEL_EN
      4'd4:    b = 9'h080;
      4'd5:    b = 9'h150;
      4'd6:    b = 9'h14C;
      4'd7:    b = 9'h141;
      4'd8:    b = 9'h143;
      4'd9:    b = 9'h141;
      4'd10:   b = 9'h152;
      4'd11:   b = 9'h120;
`endif
      default: b = 9'h000;
    endcase
    return b;
  endfunction

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic             init_done_q, init_done_d;
  logic             en_prev_q, en_prev_d;
  logic             pend_q, pend_d;
  logic [23:0]      pbuf_q, pbuf_d;
  logic [23:0]      act_q, act_d;

  logic             req;
  logic             take_pend;
  logic             take_req;
  logic             byte_done;
  logic [CNT_W-1:0] wait_last;

  // Next-state: request capture, power-up count, byte engine and sequencing.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    data_d      = data_q;
    rs_d        = rs_q;
    init_done_d = init_done_q;
    pend_d      = pend_q;
    pbuf_d      = pbuf_q;
    act_d       = act_q;
    byte_done   = 1'b0;

    // The upstream word settles after the strobe rises, so it is taken on the falling edge.
    en_prev_d = en_placar;
    req       = en_prev_q & ~en_placar;
    take_pend = (state_q == S_IDLE) & init_done_q & pend_q;
    // An idle writer with nothing buffered starts straight from the live word,
    // so busy rises on the same cycle IDLE is left.
    take_req  = (state_q == S_IDLE) & init_done_q & ~pend_q & req;

    if (take_pend) begin
      pend_d = 1'b0;
    end
    if (req && !take_req) begin
      pend_d = 1'b1;
      pbuf_d = placar_in;
    end

    wait_last = (!rs_q && data_q == 8'h01) ? CLR_LAST : CMD_LAST;

    case (state_q)
      S_PWRUP: begin
        if (cnt_q == PWR_LAST) begin
          state_d        = S_INIT;
          phase_d        = PH_SETUP;
          cnt_d          = '0;
          idx_d          = 4'd0;
          {rs_d, data_d} = init_byte(4'd0);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_IDLE: begin
        if (take_pend || take_req) begin
          act_d   = take_pend ? pbuf_q : placar_in;
          state_d = S_ADDR;
          phase_d = PH_SETUP;
          cnt_d   = '0;
          rs_d    = 1'b0;
          data_d  = ADDR_BYTE;
        end
      end
      default: begin
        case (phase_q)
          PH_SETUP: begin
            phase_d = PH_PULSE;
            cnt_d   = '0;
          end
          PH_PULSE: begin
            if (cnt_q == EN_LAST) begin
              phase_d = PH_WAIT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          PH_WAIT: begin
            if (cnt_q == wait_last) begin
              byte_done = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          default: phase_d = PH_SETUP;
        endcase

        if (byte_done) begin
          phase_d = PH_SETUP;
          cnt_d   = '0;
          case (state_q)
            S_INIT: begin
              if (idx_q == INIT_LAST) begin
                state_d     = S_IDLE;
                init_done_d = 1'b1;
              end else begin
                idx_d          = idx_q + 4'd1;
                {rs_d, data_d} = init_byte(idx_q + 4'd1);
              end
            end
            S_ADDR: begin
              state_d = S_CHAR0;
              rs_d    = 1'b1;
              data_d  = act_q[23:16];
            end
            S_CHAR0: begin
              state_d = S_CHAR1;
              rs_d    = 1'b1;
              data_d  = act_q[15:8];
            end
            S_CHAR1: begin
              state_d = S_CHAR2;
              rs_d    = 1'b1;
              data_d  = act_q[7:0];
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase

    en_d = (phase_d == PH_PULSE);
  end

  // State register with synchronous active-low reset; reset mid-byte drops lcd_en next edge.
  always_ff @(posedge clk_in) begin
    if (!i_rst_n) begin
      state_q     <= S_PWRUP;
      phase_q     <= PH_SETUP;
      cnt_q       <= '0;
      idx_q       <= 4'd0;
      data_q      <= 8'h00;
      rs_q        <= 1'b0;
      en_q        <= 1'b0;
      init_done_q <= 1'b0;
      en_prev_q   <= 1'b0;
      pend_q      <= 1'b0;
      pbuf_q      <= 24'h0;
      act_q       <= 24'h0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      en_q        <= en_d;
      init_done_q <= init_done_d;
      en_prev_q   <= en_prev_d;
      pend_q      <= pend_d;
      pbuf_q      <= pbuf_d;
      act_q       <= act_d;
    end
  end

  assign lcd_data  = data_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_en    = en_q;
  assign init_done = init_done_q;
  assign busy      = ~((state_q == S_IDLE) & ~pend_q);

endmodule

// File: tb/tb_lcd_score_writer.sv
// Bench for lcd_score_writer: scoreboard of expected LCD bytes and rise-to-rise gaps.
// Samples at negedge + 1; the monitor logs every lcd_en rise as {rs, data} with its cycle.
// Build with LCD_LABEL_EN defined to exercise the label init tail and address 0x87.
module tb_lcd_score_writer;

  localparam int P   = 20;
  localparam int EN  = 2;
  localparam int CMD = 5;
  localparam int CLR = 10;

`ifdef LCD_LABEL_EN
  localparam int         N_INIT = 12;
  localparam logic [7:0] ADDR   = 8'h87;
`else
  localparam int         N_INIT = 4;
  localparam logic [7:0] ADDR   = 8'h80;
`endif

  logic        clk_in = 1'b0;
  logic        i_rst_n;
  logic [23:0] placar_in;
  logic        en_placar;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;
  logic        busy;
  logic        init_done;

  always #5 clk_in = ~clk_in;

  lcd_score_writer #(
    .POWERUP_CYC (P),
    .EN_PULSE_CYC(EN),
    .CMD_WAIT_CYC(CMD),
    .CLR_WAIT_CYC(CLR)
  ) dut (
    .clk_in   (clk_in),
    .i_rst_n  (i_rst_n),
    .placar_in(placar_in),
    .en_placar(en_placar),
    .lcd_data (lcd_data),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_en   (lcd_en),
    .busy     (busy),
    .init_done(init_done)
  );

  int         cyc = 0;
  logic       prev_en = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int         stab_err = 0;
  int         rw_err = 0;
  logic [8:0] obs_q[$];
  int         obs_t[$];
  logic [8:0] exp_q[$];

  int         n_vec = 0;
  int         n_miss = 0;
  int         last_t = 0;
  logic [8:0] last_b = 9'h000;

  // Monitor: log each lcd_en rise, data stability while enabled, and rw held low.
  always @(negedge clk_in) begin
    cyc       <= cyc + 1;
    prev_en   <= lcd_en;
    prev_data <= lcd_data;
    if (lcd_en === 1'b1 && prev_en === 1'b0) begin
      obs_q.push_back({lcd_rs, lcd_data});
      obs_t.push_back(cyc + 1);
    end
    if (lcd_en === 1'b1 && prev_en === 1'b1 && lcd_data !== prev_data) stab_err <= stab_err + 1;
    if (lcd_rw !== 1'b0) rw_err <= rw_err + 1;
  end

  function automatic logic [8:0] init_exp(input int i);
    logic [8:0] b;
    case (i)
      0:       b = 9'h038;
      1:       b = 9'h00C;
      2:       b = 9'h006;
      3:       b = 9'h001;
      4:       b = 9'h080;
      5:       b = 9'h150;
      6:       b = 9'h14C;
      7:       b = 9'h141;
      8:       b = 9'h143;
      9:       b = 9'h141;
      10:      b = 9'h152;
      11:      b = 9'h120;
      default: b = 9'h000;
    endcase
    return b;
  endfunction

  // Rise-to-rise distance when the next byte follows directly.
  function automatic int byte_cost(input logic [8:0] b);
    return 1 + EN + ((b == 9'h001) ? CLR : CMD);
  endfunction

  task automatic step();
    @(negedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic push_init();
    for (int i = 0; i < N_INIT; i++) exp_q.push_back(init_exp(i));
  endtask

  task automatic push_score(input logic [23:0] w);
    exp_q.push_back({1'b0, ADDR});
    exp_q.push_back({1'b1, w[23:16]});
    exp_q.push_back({1'b1, w[15:8]});
    exp_q.push_back({1'b1, w[7:0]});
  endtask

  // Strobe high 3 cycles; the word only becomes valid one cycle after the rise.
  task automatic strobe(input logic [23:0] w);
    placar_in = ~w;
    en_placar = 1'b1;
    step();
    placar_in = w;
    step();
    step();
    en_placar = 1'b0;
  endtask

  // Pop n expected bytes against observed rises; first_gap < 0 skips the first gap check.
  task automatic drain(input string tag, input int n, input int first_gap);
    logic [8:0] e;
    logic [8:0] ob;
    int         t;
    int         g;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      g = (i == 0) ? first_gap : byte_cost(last_b);
      chk({tag, "_avail"}, 32'(obs_q.size() > 0), 32'd1);
      if (obs_q.size() > 0) begin
        ob = obs_q.pop_front();
        t  = obs_t.pop_front();
        chk(tag, 32'(ob), 32'(e));
        if (g >= 0) chk({tag, "_gap"}, t - last_t, g);
        last_t = t;
      end
      last_b = e;
    end
  endtask

  task automatic wait_init();
    for (int i = 0; i < 600 && init_done !== 1'b1; i++) step();
    chk("init_done_seen", 32'(init_done), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy !== 1'b0; i++) step();
    chk("busy_low_seen", 32'(busy), 32'd0);
  endtask

  task automatic wait_obs(input int n);
    for (int i = 0; i < 300 && obs_q.size() < n; i++) step();
    chk("obs_reached", 32'(obs_q.size() >= n), 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_data"}, 32'(lcd_data), 32'h00);
    chk({tag, "_rs"}, 32'(lcd_rs), 32'd0);
    chk({tag, "_rw"}, 32'(lcd_rw), 32'd0);
    chk({tag, "_en"}, 32'(lcd_en), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_initdone"}, 32'(init_done), 32'd0);
  endtask

  initial begin
    int rel;
    int t_done;
    int nb;

    i_rst_n   = 1'b0;
    en_placar = 1'b0;
    placar_in = 24'h0;
    repeat (3) step();
    chk_reset("rst");

    // Power-up and init sequence, then idle.
    push_init();
    i_rst_n = 1'b1;
    rel     = cyc;
    last_t  = rel;
    wait_init();
    chk("init_busy", 32'(busy), 32'd0);
    t_done = cyc;
    drain("init", N_INIT, P + 1);
    chk("init_done_time", t_done - last_t, EN + ((init_exp(N_INIT - 1) == 9'h001) ? CLR : CMD));

    // Single score write and busy window.
    repeat (3) step();
    push_score(24'h312C30);
    strobe(24'h312C30);
    nb = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (busy !== 1'b1) break;
      nb++;
    end
    chk("busy_len", nb, 32);
    drain("w1", 4, -1);

    // Latest score wins: 0x32 word is overwritten by 0x33 before it is served.
    push_score(24'h392C39);
    strobe(24'h392C39);
    wait_obs(2);
    strobe(24'h322C30);
    wait_obs(4);
    strobe(24'h332C30);
    push_score(24'h332C30);
    wait_idle();
    repeat (40) step();
    drain("w2a", 4, -1);
    drain("w2b", 4, byte_cost(9'h130) + 1);
    chk("w2_no_extra", obs_q.size(), 0);

    // Request before init completes is served right after init without going idle.
    i_rst_n = 1'b0;
    repeat (2) step();
    i_rst_n = 1'b1;
    rel     = cyc;
    last_t  = rel;
    push_init();
    repeat (5) step();
    push_score(24'h312C31);
    strobe(24'h312C31);
    wait_init();
    chk("early_busy_hold", 32'(busy), 32'd1);
    wait_idle();
    drain("i4", N_INIT, P + 1);
    drain("s4", 4, byte_cost(init_exp(N_INIT - 1)) + 1);

    // Reset during CHAR1 pulse discards everything, including a pending word.
    exp_q.push_back({1'b0, ADDR});
    exp_q.push_back(9'h135);
    exp_q.push_back(9'h12C);
    strobe(24'h352C35);
    wait_obs(2);
    strobe(24'h362C36);
    wait_obs(3);
    chk("mid_en_high", 32'(lcd_en), 32'd1);
    i_rst_n = 1'b0;
    step();
    chk_reset("midrst");
    step();
    i_rst_n = 1'b1;
    rel     = cyc;
    drain("w5", 3, -1);
    last_t = rel;
    push_init();
    wait_init();
    chk("no_pending_busy", 32'(busy), 32'd0);
    repeat (40) step();
    drain("i5", N_INIT, P + 1);
    chk("i5_no_extra", obs_q.size(), 0);

    chk("data_stable", stab_err, 0);
    chk("rw_low", rw_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
